// File: rtl/flt2int_if.sv
// flt2int request/result bundle.
// master drives requests, slave returns the converted integer.
interface flt2int_if;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] int_out;
    logic        done;
    logic        busy;

    modport master (
        output start, flt_in,
        input  int_out, done, busy
    );

    modport slave (
        input  start, flt_in,
        output int_out, done, busy
    );
endinterface

// File: rtl/flt2int.sv
// Half-precision float to 16-bit signed integer converter.
// Serial shifter: one bit of alignment per cycle, truncating toward zero.
module flt2int (
    input  logic      clk,
    input  logic      reset,
    flt2int_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLASS, S_SHIFT, S_NEG, S_DONE
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_flt, w_flt;
    logic [15:0] r_mag, w_mag;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_left, w_left;
    logic [15:0] r_int, w_int;

    logic        w_s;
    logic [4:0]  w_e;
    logic [9:0]  w_m;
    logic [4:0]  w_diff;

    assign w_s = r_flt[15];
    assign w_e = r_flt[14:10];
    assign w_m = r_flt[9:0];

    // distance of the exponent from the point where mantissa is integral
    assign w_diff = (w_e > 5'd25) ? (w_e - 5'd25) : (5'd25 - w_e);

    assign bus.int_out = r_int;
    assign bus.done    = (r_state == S_DONE);
    assign bus.busy    = (r_state != S_IDLE);

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_flt   <= 16'h0000;
            r_mag   <= 16'h0000;
            r_cnt   <= 4'd0;
            r_left  <= 1'b0;
            r_int   <= 16'h0000;
        end else begin
            r_state <= w_state;
            r_flt   <= w_flt;
            r_mag   <= w_mag;
            r_cnt   <= w_cnt;
            r_left  <= w_left;
            r_int   <= w_int;
        end
    end

    // next-state and datapath update
    always_comb begin
        w_state = r_state;
        w_flt   = r_flt;
        w_mag   = r_mag;
        w_cnt   = r_cnt;
        w_left  = r_left;
        w_int   = r_int;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_flt   = bus.flt_in;
                    w_state = S_CLASS;
                end
            end
            S_CLASS: begin
                if (w_e < 5'd15) begin
                    w_int   = 16'h0000;
                    w_state = S_DONE;
                end else if (w_e >= 5'd30) begin
                    // out of range, Inf and NaN all clamp by sign
                    w_int   = w_s ? 16'h8000 : 16'h7FFF;
                    w_state = S_DONE;
                end else begin
                    w_mag   = {5'b0, 1'b1, w_m};
                    w_cnt   = w_diff[3:0];
                    w_left  = (w_e > 5'd25);
                    w_state = (w_diff != 5'd0) ? S_SHIFT : S_NEG;
                end
            end
            S_SHIFT: begin
                w_mag = r_left ? (r_mag << 1) : (r_mag >> 1);
                w_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state = S_NEG;
                end
            end
            S_NEG: begin
                w_int   = w_s ? (~r_mag + 16'd1) : r_mag;
                w_state = S_DONE;
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_flt2int.sv
// Self-checking bench for flt2int: directed table, corner sequences,
// and random codes against an arithmetic reference model.
module tb_flt2int;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    flt2int_if bus ();

    flt2int dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f;
        logic [15:0] res;
        int          n;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // value = (1024+m) * 2^(e-25), truncated toward zero, then clamped
    function automatic void model(input logic [15:0] f,
                                  output logic [15:0] r, output int n);
        int     s, e, m;
        longint v;
        s = int'(f[15]);
        e = int'(f[14:10]);
        m = int'(f[9:0]);
        if (e < 15 || e >= 30) n = 2;
        else n = 3 + ((e > 25) ? e - 25 : 25 - e);
        if (e == 31) v = 100000;
        else if (e >= 25) v = longint'(1024 + m) << (e - 25);
        else v = longint'(1024 + m) >> (25 - e);
        if (s != 0) v = -v;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        r = v[15:0];
    endfunction

    task automatic run(input logic [15:0] f, output logic [15:0] res,
                       output int lat, output int bc);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flt_in = f;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.flt_in = 16'($urandom);
        lat = 0;
        bc  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
            if (bus.done) break;
        end
        res = bus.int_out;
    endtask

    task automatic conv(input string nm, input logic [15:0] f,
                        input logic [15:0] er, input int en);
        logic [15:0] r;
        int          lat, bc;
        run(f, r, lat, bc);
        chk({nm, " result"}, 32'(r), 32'(er));
        chk({nm, " latency"}, 32'(lat), 32'(en));
    endtask

    initial begin
        logic [15:0] r, er;
        int          lat, bc, en, t, prev, ndone;
        bit          seen;
        n_chk = 0;
        n_err = 0;
        bus.start  = 1'b0;
        bus.flt_in = 16'h0000;
        rst_n = 1'b0;
        #1;
        chk("reset int_out", 32'(bus.int_out), 32'h0);
        chk("reset done", 32'(bus.done), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{16'h3C00, 16'h0001, 13};
        tbl[1] = '{16'hCE00, 16'hFFE8, 9};
        tbl[2] = '{16'h77FF, 16'h7FF0, 7};
        tbl[3] = '{16'h6640, 16'h0640, 3};
        tbl[4] = '{16'hF800, 16'h8000, 2};
        tbl[5] = '{16'h7C00, 16'h7FFF, 2};
        tbl[6] = '{16'h3800, 16'h0000, 2};
        tbl[7] = '{16'hFC01, 16'h8000, 2};
        tbl[8] = '{16'h0000, 16'h0000, 2};
        tbl[9] = '{16'h4A40, 16'h000C, 10};

        for (int i = 0; i < 10; i++) begin
            run(tbl[i].f, r, lat, bc);
            chk($sformatf("vec%0d result", i), 32'(r), 32'(tbl[i].res));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].n));
            if (i == 0) chk("vec0 busy cycles", 32'(bc), 32'd13);
        end

        // reset mid-conversion, with an ignored start pulse while busy
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flt_in = 16'h3C00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.start  = 1'b1;
                bus.flt_in = 16'h6640;
            end
            if (c == 4) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort no done", 32'(seen), 32'h0);
        chk("abort int_out", 32'(bus.int_out), 32'h0);
        chk("abort busy", 32'(bus.busy), 32'h0);
        chk("abort done", 32'(bus.done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        conv("post-reset", 16'h4A40, 16'h000C, 10);

        // start held high: new job each return to IDLE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flt_in = 16'h4400;
        t = 0;
        prev = 0;
        ndone = 0;
        for (int k = 0; k < 80 && ndone < 3; k++) begin
            @(negedge clk);
            t++;
            if (bus.done) begin
                chk($sformatf("b2b%0d result", ndone),
                    32'(bus.int_out), 32'h0004);
                if (ndone > 0)
                    chk($sformatf("b2b%0d period", ndone),
                        32'(t - prev), 32'd12);
                prev = t;
                ndone++;
            end
        end
        chk("b2b done count", 32'(ndone), 32'd3);
        bus.start = 1'b0;
        for (int k = 0; k < 30 && bus.busy; k++) @(negedge clk);
        chk("b2b idle", 32'(bus.busy), 32'h0);

        // every sign/exponent pair with a random mantissa
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 32; e++) begin
                logic [15:0] f;
                f = {1'(s), 5'(e), 10'($urandom)};
                model(f, er, en);
                conv($sformatf("se %h", f), f, er, en);
            end
        end

        // random codes
        for (int i = 0; i < 2500; i++) begin
            logic [15:0] f;
            f = 16'($urandom);
            model(f, er, en);
            conv($sformatf("rnd %h", f), f, er, en);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
